// File: rtl/sha256_compress.sv
// SHA-256 compression rounds: accepts one schedule word per cycle, runs 64 rounds, then adds the
// working variables into the chaining value. Define SHA256_IV_SELECT_EN to add first_block (load FIPS IV).
module sha256_compress #(
    parameter int ROUNDS = 64
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
`ifdef SHA256_IV_SELECT_EN
    input  logic         first_block,
`endif
    input  logic [255:0] hash_in,
    input  logic         w_valid,
    input  logic [31:0]  w_word,
    output logic         w_ready,
    output logic         busy,
    output logic [5:0]   round_index,
    output logic         digest_valid,
    output logic [255:0] digest
);
    localparam int RW = $clog2(ROUNDS);
`ifdef SHA256_IV_SELECT_EN
    localparam logic [255:0] IV =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
`endif

    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL} state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   round_q, round_d;
    logic            w_ready_q, w_ready_d;
    logic            busy_q, busy_d;
    logic            digest_valid_q, digest_valid_d;
    logic [255:0]    digest_q, digest_d;
    logic [255:0]    h_save_q, h_save_d;
    logic [31:0]     a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q;
    logic [31:0]     a_d, b_d, c_d, d_d, e_d, f_d, g_d, h_d;
    logic [31:0]     t1, t2;
    logic [255:0]    work;
    logic [255:0]    load_val;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic [31:0] k_rom(input logic [5:0] t);
        logic [31:0] k;
        case (t)
            6'd0:  k = 32'h428a2f98;  6'd1:  k = 32'h71374491;
            6'd2:  k = 32'hb5c0fbcf;  6'd3:  k = 32'he9b5dba5;
            6'd4:  k = 32'h3956c25b;  6'd5:  k = 32'h59f111f1;
            6'd6:  k = 32'h923f82a4;  6'd7:  k = 32'hab1c5ed5;
            6'd8:  k = 32'hd807aa98;  6'd9:  k = 32'h12835b01;
            6'd10: k = 32'h243185be;  6'd11: k = 32'h550c7dc3;
            6'd12: k = 32'h72be5d74;  6'd13: k = 32'h80deb1fe;
            6'd14: k = 32'h9bdc06a7;  6'd15: k = 32'hc19bf174;
            6'd16: k = 32'he49b69c1;  6'd17: k = 32'hefbe4786;
            6'd18: k = 32'h0fc19dc6;  6'd19: k = 32'h240ca1cc;
            6'd20: k = 32'h2de92c6f;  6'd21: k = 32'h4a7484aa;
            6'd22: k = 32'h5cb0a9dc;  6'd23: k = 32'h76f988da;
            6'd24: k = 32'h983e5152;  6'd25: k = 32'ha831c66d;
            6'd26: k = 32'hb00327c8;  6'd27: k = 32'hbf597fc7;
            6'd28: k = 32'hc6e00bf3;  6'd29: k = 32'hd5a79147;
            6'd30: k = 32'h06ca6351;  6'd31: k = 32'h14292967;
            6'd32: k = 32'h27b70a85;  6'd33: k = 32'h2e1b2138;
            6'd34: k = 32'h4d2c6dfc;  6'd35: k = 32'h53380d13;
            6'd36: k = 32'h650a7354;  6'd37: k = 32'h766a0abb;
            6'd38: k = 32'h81c2c92e;  6'd39: k = 32'h92722c85;
            6'd40: k = 32'ha2bfe8a1;  6'd41: k = 32'ha81a664b;
            6'd42: k = 32'hc24b8b70;  6'd43: k = 32'hc76c51a3;
            6'd44: k = 32'hd192e819;  6'd45: k = 32'hd6990624;
            6'd46: k = 32'hf40e3585;  6'd47: k = 32'h106aa070;
            6'd48: k = 32'h19a4c116;  6'd49: k = 32'h1e376c08;
            6'd50: k = 32'h2748774c;  6'd51: k = 32'h34b0bcb5;
            6'd52: k = 32'h391c0cb3;  6'd53: k = 32'h4ed8aa4a;
            6'd54: k = 32'h5b9cca4f;  6'd55: k = 32'h682e6ff3;
            6'd56: k = 32'h748f82ee;  6'd57: k = 32'h78a5636f;
            6'd58: k = 32'h84c87814;  6'd59: k = 32'h8cc70208;
            6'd60: k = 32'h90befffa;  6'd61: k = 32'ha4506ceb;
            6'd62: k = 32'hbef9a3f7;
            default: k = 32'hc67178f2;
        endcase
        return k;
    endfunction

    always_comb begin
        state_d        = state_q;
        round_d        = round_q;
        digest_d       = digest_q;
        digest_valid_d = 1'b0;
        h_save_d       = h_save_q;
        {a_d, b_d, c_d, d_d, e_d, f_d, g_d, h_d} = {a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q};
        work = {a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q};
        t1   = h_q + big_sigma1(e_q) + ch(e_q, f_q, g_q) + k_rom(round_q) + w_word;
        t2   = big_sigma0(a_q) + maj(a_q, b_q, c_q);
`ifdef SHA256_IV_SELECT_EN
        load_val = first_block ? IV : hash_in;
`else
        load_val = hash_in;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    h_save_d = load_val;
                    {a_d, b_d, c_d, d_d, e_d, f_d, g_d, h_d} = load_val;
                    round_d  = '0;
                    state_d  = S_ROUND;
                end
            end
            S_ROUND: begin
                // A low w_valid simply stalls every register in place
                if (w_valid) begin
                    h_d = g_q;
                    g_d = f_q;
                    f_d = e_q;
                    e_d = d_q + t1;
                    d_d = c_q;
                    c_d = b_q;
                    b_d = a_q;
                    a_d = t1 + t2;
                    round_d = round_q + 1'b1;
                    if (round_q == RW'(ROUNDS - 1)) begin
                        state_d = S_FINAL;
                    end
                end
            end
            S_FINAL: begin
                for (int i = 0; i < 8; i++) begin
                    digest_d[255 - 32*i -: 32] = h_save_q[255 - 32*i -: 32] + work[255 - 32*i -: 32];
                end
                digest_valid_d = 1'b1;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        w_ready_d = (state_d == S_ROUND);
        busy_d    = (state_d != S_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= S_IDLE;
            round_q        <= '0;
            w_ready_q      <= 1'b0;
            busy_q         <= 1'b0;
            digest_valid_q <= 1'b0;
            digest_q       <= '0;
            {a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q} <= '0;
        end else begin
            state_q        <= state_d;
            round_q        <= round_d;
            w_ready_q      <= w_ready_d;
            busy_q         <= busy_d;
            digest_valid_q <= digest_valid_d;
            digest_q       <= digest_d;
            h_save_q       <= h_save_d;
            {a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q} <= {a_d, b_d, c_d, d_d, e_d, f_d, g_d, h_d};
        end
    end

    assign w_ready      = w_ready_q;
    assign busy         = busy_q;
    assign round_index  = round_q;
    assign digest_valid = digest_valid_q;
    assign digest       = digest_q;

endmodule

// File: doc/sha256_compress.md
Name: sha256_compress

Overview:
- SHA-256 compression-round engine; sits directly downstream of the message-schedule stage.
- Consumes one 32-bit schedule word W[t] per accepted cycle and runs the 64 compression rounds.
- Adds the working variables back into the chaining value and presents a 256-bit digest with a one-cycle valid pulse.
- Chaining value comes from the previous block's digest, or from the standard IV when the optional feature is enabled.

Parameters:
- ROUNDS, 64, number of rounds per block. Fixed at 64 for SHA-256; other values unsupported. Sizes the round counter to $clog2(ROUNDS) bits.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  begin a block; sampled only in IDLE
- hash_in  input  256  chaining value H0..H7; H0 = [255:224]
- w_valid  input  1  W word on w_word is valid
- w_word  input  32  schedule word W[t], delivered in order t = 0..63
- w_ready  output  1  engine will accept W this cycle
- busy  output  1  block in progress (not IDLE)
- round_index  output  6  index t of the next W expected
- digest_valid  output  1  one-cycle pulse: digest updated
- digest  output  256  final hash; H0 = [255:224]

Behaviour:
- Reset values: w_ready=0, busy=0, round_index=0, digest_valid=0, digest=0, working regs a..h=0, state=IDLE. Reset overrides every other input, including mid-block; a partial block is discarded.
- Constants: K[0..63] per FIPS 180-4 in a case-based ROM indexed by round_index.
- All additions are mod 2^32. Rotations are true 32-bit rotates.
- IDLE:
  - w_ready=0, busy=0.
  - On start=1: latch hash_in into H_save and into a..h, clear round_index, go to ROUND.
- ROUND:
  - w_ready=1, busy=1.
  - If w_valid=0: all registers hold (stall); no timeout.
  - If w_valid=1, one round is performed:
    - T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + W
    - T2 = Σ0(a) + Maj(a,b,c)
    - h←g, g←f, f←e, e←d+T1, d←c, c←b, b←a, a←T1+T2
    - round_index increments.
  - Σ0 = ROTR2^ROTR13^ROTR22. Σ1 = ROTR6^ROTR11^ROTR25.
  - Ch = (e&f)^(~e&g). Maj = (a&b)^(a&c)^(b&c).
  - When the word with t=63 is accepted: go to FINAL; round_index wraps to 0.
- FINAL (one cycle):
  - w_ready=0, busy=1.
  - digest ← {H_save[i] + working[i]} for i=0..7.
  - digest_valid asserted the following cycle for exactly one cycle; return to IDLE.
- digest holds its value until the next FINAL or reset.
- Latency: with w_valid held high, the first W is accepted the cycle after start. digest_valid rises 66 cycles after the start cycle (1 load + 64 rounds + 1 final).
- start while busy is ignored, with no effect on the current block.
- start asserted in the same cycle digest_valid is high is legal; the new block loads normally.
- w_valid while w_ready=0 is ignored; no word is consumed.
- Back-to-back blocks: the caller feeds digest back as hash_in and asserts start the cycle digest_valid is seen. Minimum block period 66 cycles.

Optional Feature:
- Macro: SHA256_IV_SELECT_EN.
- Defined:
  - Extra input first_block (1 bit), sampled with start.
  - When first_block=1, a..h and H_save load the FIPS IV (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19) and hash_in is ignored.
  - When first_block=0, hash_in is used.
- Not defined: port absent; hash_in always used.

Test Plan:
- "abc" single block: hash_in=IV, W[0..63] from the padded "abc" block, w_valid held high → after round 0, a=5d6aebcd and e=fa2a4622; digest=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad; digest_valid pulse 66 cycles after start.
- Empty message: hash_in=IV, padded block 80000000 followed by zeros → digest=e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Stall: "abc" vector with w_valid deasserted for 3 cycles at t=10 and at t=63 → same digest; digest_valid delayed by exactly 6 cycles; round_index frozen during stalls.
- Reset mid-block: reset asserted at t=30 → next cycle busy=0, digest=0, digest_valid=0. A fresh "abc" run afterwards yields the correct digest.
- start while busy: pulse start at t=20 with a different hash_in → ignored; digest matches the "abc" vector.
- Two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq": chain digest into hash_in → final digest=248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1. Repeat with SHA256_IV_SELECT_EN defined, first_block=1 on block 1 and hash_in=0 → same digest.
